// File: rtl/aes_word_loader_pkg.sv
// aes_pkg: types and constants shared by the AES word loader and its packer.
//   AES_BLK_W      - width of one AES block / key (128)
//   AES_WORD_W     - width of one stream word (32)
//   loader_state_t - loader FSM states
package aes_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } loader_state_t;

endpackage

// File: rtl/aes_word_loader_packer.sv
// aes_word_packer: 4-word assembly shift register.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : synchronous clear of the assembly register
//   i_load     : shift i_word into the register this cycle
//   i_word     : incoming 32-bit word
//   o_next     : assembly contents including i_word when i_load is high,
//                so the owner can capture a completed group on the 4th word
module aes_word_packer
  import aes_pkg::*;
#(
  parameter int WORD_FIRST_MSB = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic [AES_WORD_W-1:0] i_word,
  output logic [AES_BLK_W-1:0]  o_next
);

  logic [AES_BLK_W-1:0] r_asm;
  logic [AES_BLK_W-1:0] w_shifted;

  // Shift direction decides where the first word of a group ends up.
  always_comb begin
    w_shifted = r_asm;
    if (WORD_FIRST_MSB != 0) begin
      w_shifted = {r_asm[AES_BLK_W-AES_WORD_W-1:0], i_word};
    end else begin
      w_shifted = {i_word, r_asm[AES_BLK_W-1:AES_WORD_W]};
    end
  end

  assign o_next = i_load ? w_shifted : r_asm;

  // Assembly register: clear has priority over a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm <= {AES_BLK_W{1'b0}};
    end else if (i_clr) begin
      r_asm <= {AES_BLK_W{1'b0}};
    end else if (i_load) begin
      r_asm <= w_shifted;
    end
  end

endmodule

// File: rtl/aes_word_loader.sv
// aes_word_loader: assembles 32-bit stream words into 128-bit key and
// plaintext groups and presents a stable {key, plaintext} pair to a
// combinational AES-128 core under a valid/ready block handshake.
//   clk, rst_n           : clock, async active-low reset
//   flush                : synchronous clear of partial group, block and key
//   s_data/s_is_key      : input word and its group kind (1 = key)
//   s_valid/s_ready      : word handshake (s_ready is registered)
//   blk_data/blk_key     : plaintext / key to the core
//   blk_valid/blk_ready  : block handshake
//   key_valid            : a complete key is loaded
//   err                  : one-cycle pulse on a protocol error
module aes_word_loader
  import aes_pkg::*;
#(
  parameter int WORD_FIRST_MSB = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [AES_WORD_W-1:0] s_data,
  input  logic                  s_is_key,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [AES_BLK_W-1:0]  blk_data,
  output logic [AES_BLK_W-1:0]  blk_key,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic                  key_valid,
  output logic                  err
);

  loader_state_t        r_state;
  loader_state_t        w_state_next;
  logic [1:0]           r_wcnt;
  logic [1:0]           w_wcnt_next;
  logic                 r_kind;
  logic                 r_s_ready;
  logic                 r_blk_valid;
  logic                 r_key_valid;
  logic                 r_err;
  logic [AES_BLK_W-1:0] r_blk_data;
  logic [AES_BLK_W-1:0] r_blk_key;

  logic                 w_accept;
  logic                 w_kind;
  logic                 w_mismatch;
  logic                 w_last;
  logic                 w_key_done;
  logic                 w_pt_done;
  logic                 w_pt_drop;
  logic                 w_load;
  logic                 w_clr;
  logic [AES_BLK_W-1:0] w_asm_next;

  // Word-level event decode for the current cycle.
  always_comb begin
    w_accept   = s_valid && r_s_ready;
    // Word 0 defines the group kind; later words are compared to the latch.
    w_kind     = (r_wcnt == 2'd0) ? s_is_key : r_kind;
    w_mismatch = w_accept && (r_wcnt != 2'd0) && (s_is_key != r_kind);
    w_last     = w_accept && !w_mismatch && (r_wcnt == 2'd3);
    w_key_done = w_last && w_kind;
    w_pt_done  = w_last && !w_kind;
    w_pt_drop  = w_pt_done && !r_key_valid;
    w_load     = w_accept && !w_mismatch && !flush;
    w_clr      = flush || w_mismatch;
  end

  aes_word_packer #(
    .WORD_FIRST_MSB(WORD_FIRST_MSB)
  ) u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_load (w_load),
    .i_word (s_data),
    .o_next (w_asm_next)
  );

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = COLLECT;
        end else begin
          w_state_next = IDLE;
        end
      end
      COLLECT: begin
        if (w_mismatch || w_key_done || w_pt_drop) begin
          w_state_next = IDLE;
        end else if (w_pt_done) begin
          w_state_next = PRESENT;
        end else begin
          w_state_next = COLLECT;
        end
      end
      PRESENT: begin
        if (blk_ready) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = PRESENT;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      w_state_next = w_state_next;
    end
  end

  // Word counter next value: wraps 3 -> 0 on a completed group.
  always_comb begin
    w_wcnt_next = r_wcnt;
    if (flush || w_mismatch) begin
      w_wcnt_next = 2'd0;
    end else if (w_accept) begin
      w_wcnt_next = r_wcnt + 2'd1;
    end else begin
      w_wcnt_next = r_wcnt;
    end
  end

  // FSM state, word counter and latched group kind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wcnt  <= 2'd0;
      r_kind  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
      if (w_accept && (r_wcnt == 2'd0) && !flush) begin
        r_kind <= s_is_key;
      end
    end
  end

  // Registered status flags; s_ready/blk_valid are decoded from next state
  // so they never depend combinationally on s_valid or blk_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_ready   <= 1'b1;
      r_blk_valid <= 1'b0;
      r_key_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_s_ready   <= (w_state_next != PRESENT);
      r_blk_valid <= (w_state_next == PRESENT);
      r_err       <= !flush && (w_mismatch || w_pt_drop);
      if (flush) begin
        r_key_valid <= 1'b0;
      end else if (w_key_done) begin
        r_key_valid <= 1'b1;
      end
    end
  end

  // Key and plaintext holding registers; only written outside PRESENT,
  // because no word can be accepted while a block is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_key  <= {AES_BLK_W{1'b0}};
      r_blk_data <= {AES_BLK_W{1'b0}};
    end else begin
      if (!flush && w_key_done) begin
        r_blk_key <= w_asm_next;
      end
      if (!flush && w_pt_done && r_key_valid) begin
        r_blk_data <= w_asm_next;
      end
    end
  end

  assign s_ready   = r_s_ready;
  assign blk_valid = r_blk_valid;
  assign key_valid = r_key_valid;
  assign err       = r_err;
  assign blk_key   = r_blk_key;
  assign blk_data  = r_blk_data;

endmodule

// File: tb/tb_aes_word_loader.sv
// Testbench for aes_word_loader. Two instances share all control inputs:
// dut0 uses WORD_FIRST_MSB=1, dut1 uses WORD_FIRST_MSB=0 and gets its own
// data word so groups can be fed in reversed order. A reference AES-128
// model stands in for the downstream core.
module tb_aes_word_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [31:0]  s_data;
  logic [31:0]  s_data1;
  logic         s_is_key;
  logic         s_valid;
  logic         blk_ready;
  logic         s_ready0, s_ready1;
  logic [127:0] blk_data0, blk_data1, blk_key0, blk_key1;
  logic         blk_valid0, blk_valid1, key_valid0, key_valid1, err0, err1;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BP_PT   = 128'hdeadbeef0123456789abcdefcafef00d;

  aes_word_loader #(.WORD_FIRST_MSB(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s_data(s_data),
    .s_is_key(s_is_key), .s_valid(s_valid), .s_ready(s_ready0),
    .blk_data(blk_data0), .blk_key(blk_key0), .blk_valid(blk_valid0),
    .blk_ready(blk_ready), .key_valid(key_valid0), .err(err0)
  );

  aes_word_loader #(.WORD_FIRST_MSB(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s_data(s_data1),
    .s_is_key(s_is_key), .s_valid(s_valid), .s_ready(s_ready1),
    .blk_data(blk_data1), .blk_key(blk_key1), .blk_valid(blk_valid1),
    .blk_ready(blk_ready), .key_valid(key_valid1), .err(err1)
  );

  always #5 clk = ~clk;

  // ---------------- reference AES-128 encryption ----------------
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  t;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
            ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_tab[st[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) tmp[rw+4*c] = st[rw+4*((c+rw)%4)];
      for (int i = 0; i < 16; i++) st[i] = tmp[i];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] d1, input logic k);
    s_valid = 1'b1; s_data = d; s_data1 = d1; s_is_key = k;
    step();
  endtask

  typedef struct {
    logic [31:0] d;
    logic [31:0] d1;
    logic        k;
    logic        e_err;
    logic        e_kv;
    logic        e_bv;
    logic [1:0]  e_wc;
  } vec_t;

  vec_t vt [15];

  initial begin
    // plaintext group before any key: dropped with err on the 4th word
    vt[0]  = '{32'h11111111, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    vt[1]  = '{32'h22222222, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
    vt[2]  = '{32'h33333333, 32'h33333333, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
    vt[3]  = '{32'h44444444, 32'h44444444, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    // mixed group key,key,plaintext: err on the 3rd word, counter back to 0
    vt[4]  = '{32'haaaa0000, 32'haaaa0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
    vt[5]  = '{32'haaaa1111, 32'haaaa1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
    vt[6]  = '{32'haaaa2222, 32'haaaa2222, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    // FIPS-197 key; dut1 gets the words reversed
    vt[7]  = '{32'h00010203, 32'h0c0d0e0f, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
    vt[8]  = '{32'h04050607, 32'h08090a0b, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
    vt[9]  = '{32'h08090a0b, 32'h04050607, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3};
    vt[10] = '{32'h0c0d0e0f, 32'h00010203, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    // FIPS-197 plaintext
    vt[11] = '{32'h00112233, 32'hccddeeff, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    vt[12] = '{32'h44556677, 32'h8899aabb, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    vt[13] = '{32'h8899aabb, 32'h44556677, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3};
    vt[14] = '{32'hccddeeff, 32'h00112233, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};

    for (int i = 0; i < 256; i++) sbox_tab[i] = calc_sbox(8'(i));

    rst_n = 1'b0; flush = 1'b0; s_data = 32'h0; s_data1 = 32'h0;
    s_is_key = 1'b0; s_valid = 1'b0; blk_ready = 1'b1;
    step(); step();

    // reset state
    chk("rst_s_ready",   128'(s_ready0),   128'(1'b1));
    chk("rst_blk_valid", 128'(blk_valid0), 128'(1'b0));
    chk("rst_key_valid", 128'(key_valid0), 128'(1'b0));
    chk("rst_err",       128'(err0),       128'(1'b0));
    chk("rst_blk_data",  blk_data0,        128'h0);
    chk("rst_blk_key",   blk_key0,         128'h0);
    rst_n = 1'b1;
    step();

    // table-driven word sequence
    for (int i = 0; i < 15; i++) begin
      blk_ready = 1'b1;
      send(vt[i].d, vt[i].d1, vt[i].k);
      chk($sformatf("v%0d_err", i),       128'(err0),            128'(vt[i].e_err));
      chk($sformatf("v%0d_key_valid", i), 128'(key_valid0),      128'(vt[i].e_kv));
      chk($sformatf("v%0d_blk_valid", i), 128'(blk_valid0),      128'(vt[i].e_bv));
      chk($sformatf("v%0d_s_ready", i),   128'(s_ready0),        128'(!vt[i].e_bv));
      chk($sformatf("v%0d_wcnt", i),      128'(dut0.r_wcnt),     128'(vt[i].e_wc));
      chk($sformatf("v%0d_blk_valid1", i), 128'(blk_valid1),     128'(vt[i].e_bv));
    end
    s_valid = 1'b0;

    // known-answer results in the presentation cycle, both orderings
    chk("kat_key0",  blk_key0,  KAT_KEY);
    chk("kat_data0", blk_data0, KAT_PT);
    chk("kat_ct0",   aes_enc(blk_key0, blk_data0), KAT_CT);
    chk("kat_key1",  blk_key1,  KAT_KEY);
    chk("kat_data1", blk_data1, KAT_PT);
    chk("kat_ct1",   aes_enc(blk_key1, blk_data1), KAT_CT);
    step();
    chk("kat_bv_one_cycle", 128'(blk_valid0), 128'(1'b0));
    chk("kat_s_ready_back", 128'(s_ready0),   128'(1'b1));
    chk("kat_data_held",    blk_data0,        KAT_PT);

    // backpressure: 10 cycles of blk_ready=0 with s_valid held high
    blk_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(BP_PT[127-32*i -: 32], BP_PT[127-32*i -: 32], 1'b0);
    end
    chk("bp_blk_valid", 128'(blk_valid0), 128'(1'b1));
    s_data = 32'h55555555; s_data1 = 32'h55555555; s_is_key = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp%0d_s_ready", i),   128'(s_ready0),   128'(1'b0));
      chk($sformatf("bp%0d_blk_valid", i), 128'(blk_valid0), 128'(1'b1));
      chk($sformatf("bp%0d_data", i),      blk_data0,        BP_PT);
      chk($sformatf("bp%0d_key", i),       blk_key0,         KAT_KEY);
    end
    blk_ready = 1'b1;
    step();
    s_valid = 1'b0;
    chk("bp_release_blk_valid", 128'(blk_valid0),  128'(1'b0));
    chk("bp_release_s_ready",   128'(s_ready0),    128'(1'b1));
    chk("bp_release_wcnt",      128'(dut0.r_wcnt), 128'(2'd0));
    step();

    // flush while presenting
    blk_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h12345678, 32'h12345678, 1'b0);
    chk("fl1_presenting", 128'(blk_valid0), 128'(1'b1));
    flush = 1'b1; s_valid = 1'b1; s_is_key = 1'b0;
    step();
    flush = 1'b0; s_valid = 1'b0;
    chk("fl1_blk_valid", 128'(blk_valid0),  128'(1'b0));
    chk("fl1_key_valid", 128'(key_valid0),  128'(1'b0));
    chk("fl1_wcnt",      128'(dut0.r_wcnt), 128'(2'd0));
    chk("fl1_err",       128'(err0),        128'(1'b0));
    chk("fl1_s_ready",   128'(s_ready0),    128'(1'b1));
    step();
    chk("fl1_err_after", 128'(err0), 128'(1'b0));

    // flush at word 2 of a key group
    blk_ready = 1'b1;
    send(32'h01010101, 32'h01010101, 1'b1);
    send(32'h02020202, 32'h02020202, 1'b1);
    chk("fl2_wcnt_before", 128'(dut0.r_wcnt), 128'(2'd2));
    flush = 1'b1; s_data = 32'h03030303; s_data1 = 32'h03030303; s_valid = 1'b1;
    step();
    flush = 1'b0; s_valid = 1'b0;
    chk("fl2_wcnt",      128'(dut0.r_wcnt), 128'(2'd0));
    chk("fl2_key_valid", 128'(key_valid0),  128'(1'b0));
    chk("fl2_blk_valid", 128'(blk_valid0),  128'(1'b0));
    chk("fl2_err",       128'(err0),        128'(1'b0));
    step();
    chk("fl2_err_after", 128'(err0), 128'(1'b0));
    // two more key words now start a fresh group
    send(32'h04040404, 32'h04040404, 1'b1);
    send(32'h05050505, 32'h05050505, 1'b1);
    s_valid = 1'b0;
    chk("fl2_restart_wcnt", 128'(dut0.r_wcnt), 128'(2'd2));
    chk("fl2_restart_kv",   128'(key_valid0),  128'(1'b0));

    // asynchronous reset mid-group, checked before the next clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_s_ready",   128'(s_ready0),     128'(1'b1));
    chk("arst_blk_valid", 128'(blk_valid0),   128'(1'b0));
    chk("arst_key_valid", 128'(key_valid0),   128'(1'b0));
    chk("arst_err",       128'(err0),         128'(1'b0));
    chk("arst_blk_data",  blk_data0,          128'h0);
    chk("arst_blk_key",   blk_key0,           128'h0);
    chk("arst_wcnt",      128'(dut0.r_wcnt),  128'(2'd0));
    chk("arst_state",     128'(dut0.r_state), 128'(2'd0));
    chk("arst_blk_key1",  blk_key1,           128'h0);
    #2;
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_word_loader.md
# aes_word_loader

Upstream feeder for the combinational AES-128 encryption core. It accepts 32-bit words over a valid/ready stream, assembles 128-bit key and plaintext groups, and holds a stable `{key, plaintext}` pair on the core inputs under a valid/ready block handshake. The consumer samples the core output in the handshake cycle.

## Interface

Parameters:
- `WORD_FIRST_MSB`, default 1: 1 places the first word of a group in bits [127:96] and the fourth in [31:0]; 0 reverses the order (first word in [31:0]).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear; drops the partial group, the pending block and the key.
- `s_data`  in  32  input word.
- `s_is_key`  in  1  word belongs to a key group (1) or a plaintext group (0).
- `s_valid`  in  1  word valid.
- `s_ready`  out  1  loader can accept a word.
- `blk_data`  out  128  plaintext to core `in`.
- `blk_key`  out  128  key to core `key`.
- `blk_valid`  out  1  block pair stable and presented.
- `blk_ready`  in  1  consumer accepts the block (and the core output) this cycle.
- `key_valid`  out  1  a complete key has been loaded.
- `err`  out  1  one-cycle pulse on a protocol error.

## Operation

- Word accept occurs when `s_valid && s_ready`. A 2-bit word counter `wcnt` counts accepts within the current group.
- Group kind is latched from `s_is_key` on word 0. If words 1–3 carry a different `s_is_key`:
  - `err` pulses.
  - The group is discarded and `wcnt` returns to 0.
  - The offending word is dropped.
- Words shift into a 128-bit assembly register in the order set by `WORD_FIRST_MSB`.
- On the 4th key word:
  - `blk_key` is loaded and `key_valid` is set to 1.
  - The FSM returns to IDLE. No block is presented.
- On the 4th plaintext word:
  - If `key_valid` is 1, `blk_data` is loaded and the FSM goes to PRESENT.
  - If `key_valid` is 0, `err` pulses, the block is dropped and the FSM goes to IDLE.
- FSM states and transitions:
  - IDLE (`wcnt`=0) goes to COLLECT on a word accept.
  - COLLECT (`wcnt`=1..3) goes to IDLE on a key completion, a mismatch or a dropped block.
  - COLLECT goes to PRESENT on a plaintext completion with a key loaded.
  - PRESENT goes to IDLE when `blk_ready` is sampled 1.
- `s_ready` is 1 in IDLE and COLLECT and 0 in PRESENT. As a result, `blk_key` and `blk_data` are never modified while `blk_valid` is 1.
- `flush` has priority over all other events in the same cycle:
  - FSM goes to IDLE and `wcnt` goes to 0.
  - `blk_valid` and `key_valid` go to 0.
  - `err` is not pulsed.
  - A word accepted in the flush cycle is discarded.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

## Timing

- Reset values:
  - `s_ready`=1, `blk_valid`=0, `key_valid`=0, `err`=0.
  - `blk_data`=0, `blk_key`=0, FSM=IDLE, `wcnt`=0.
- `blk_valid` rises in the cycle after the 4th plaintext word's handshake, so the loader latency is 1 cycle.
- The core output is valid combinationally in the same cycle as `blk_valid`.
- When `blk_valid && blk_ready` is sampled:
  - `blk_valid` falls and `s_ready` rises in the next cycle.
  - `blk_data` keeps its value until it is overwritten.
- Peak throughput is one block per 5 cycles: 4 accepts plus 1 present cycle with `blk_ready` held 1.
- `key_valid` rises in the cycle after the 4th key word.
- A plaintext group may begin in the cycle `key_valid` rises.
- `err` is registered and rises in the cycle after the offending accept.
- `s_ready` is registered. It does not depend combinationally on `s_valid` or `blk_ready`.

## Structure

- Shared package `aes_pkg` holds:
  - `AES_BLK_W`=128 and `AES_WORD_W`=32.
  - The FSM enum `loader_state_t` {IDLE, COLLECT, PRESENT}.
- Sub-module `aes_word_packer` is a 4-word shift/assembly register with the `WORD_FIRST_MSB` ordering, a load strobe and a clear.
- FSM, counter and key/valid flags live in the top module.
- The AES core is instantiated by the parent, not by this block.

## Test plan

- FIPS-197 known-answer test:
  - Stimulus: key words 00010203, 04050607, 08090a0b, 0c0d0e0f, then plaintext words 00112233, 44556677, 8899aabb, ccddeeff, with `blk_ready`=1 and `WORD_FIRST_MSB`=1.
  - Required: `blk_valid` for one cycle and core output 69c4e0d86a7b0430d8cdb78070b4c55a.
- Plaintext before key:
  - Stimulus: 4 plaintext words after reset.
  - Required: `err` pulses, `blk_valid` stays 0, `key_valid`=0.
- Mixed group:
  - Stimulus: `s_is_key`=1,1,0 on words 0–2.
  - Required: `err` pulses on the 3rd word and `wcnt` returns to 0. A following full key group then loads correctly.
- Backpressure:
  - Stimulus: `blk_ready`=0 for 10 cycles after a block is presented, with `s_valid`=1 throughout.
  - Required: `s_ready`=0 and `blk_data`/`blk_key` are unchanged all 10 cycles. One cycle after `blk_ready`=1, `s_ready`=1.
- Flush:
  - Stimulus: `flush` asserted while presenting, then `flush` asserted at word 2 of a group, each case with `s_valid` high.
  - Required: next cycle `blk_valid`=0, `key_valid`=0, `wcnt`=0, and no `err`.
- Reset and ordering:
  - Stimulus: assert `rst_n`=0 asynchronously mid-group.
  - Required: all outputs reach reset values before the next edge.
  - Stimulus: repeat the known-answer test with `WORD_FIRST_MSB`=0 and reversed word order.
  - Required: identical ciphertext.
